// File: rtl/jtag_tap_sampled.sv
// IEEE 1149.1 TAP controller that oversamples the JTAG pins with the system clock.
// Pin edges are detected after synchronisation, and all TAP activity runs in the clock domain.
module jtag_tap_sampled #(
  parameter logic [31:0] IDCODE      = 32'h00000001,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        jtag_TCK,
  input  logic        jtag_TMS,
  input  logic        jtag_TDI,
  input  logic        jtag_TRSTn,
  output logic        jtag_TDO_data,
  output logic        jtag_TDO_driven,
  input  logic [31:0] user_capture_data,
  output logic        user_update_valid,
  output logic [31:0] user_update_data,
  output logic [3:0]  tap_state
);

  typedef enum logic [3:0] {
    EX2_DR = 4'd0,  EX1_DR = 4'd1,  SH_DR  = 4'd2,  PAU_DR = 4'd3,
    SEL_IR = 4'd4,  UPD_DR = 4'd5,  CAP_DR = 4'd6,  SEL_DR = 4'd7,
    EX2_IR = 4'd8,  EX1_IR = 4'd9,  SH_IR  = 4'd10, PAU_IR = 4'd11,
    RTI    = 4'd12, UPD_IR = 4'd13, CAP_IR = 4'd14, TLR    = 4'd15
  } tap_state_t;

  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_USER   = 5'h10;

  logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync, trstn_sync;
  logic                   tck_prev;
  logic                   tck_s, tms_s, tdi_s, trstn_s;
  logic                   tck_rise, tck_fall;

  tap_state_t state;
  logic [4:0] ir;
  logic [4:0] ir_shift;
  logic [31:0] dr_shift;
  logic       wide_dr;

  // Synchronizers reset to the idle levels of the pins so leaving reset never fakes an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      tck_sync   <= '0;
      tms_sync   <= '1;
      tdi_sync   <= '0;
      trstn_sync <= '1;
      tck_prev   <= 1'b0;
    end else begin
      tck_sync   <= {tck_sync[SYNC_STAGES-2:0], jtag_TCK};
      tms_sync   <= {tms_sync[SYNC_STAGES-2:0], jtag_TMS};
      tdi_sync   <= {tdi_sync[SYNC_STAGES-2:0], jtag_TDI};
      trstn_sync <= {trstn_sync[SYNC_STAGES-2:0], jtag_TRSTn};
      tck_prev   <= tck_sync[SYNC_STAGES-1];
    end
  end

  assign tck_s    = tck_sync[SYNC_STAGES-1];
  assign tms_s    = tms_sync[SYNC_STAGES-1];
  assign tdi_s    = tdi_sync[SYNC_STAGES-1];
  assign trstn_s  = trstn_sync[SYNC_STAGES-1];
  assign tck_rise = tck_s & ~tck_prev;
  assign tck_fall = ~tck_s & tck_prev;
  assign wide_dr  = (ir == IR_IDCODE) || (ir == IR_USER);

  function automatic tap_state_t next_of(input tap_state_t s, input logic tms);
    case (s)
      TLR:     return tms ? TLR    : RTI;
      RTI:     return tms ? SEL_DR : RTI;
      SEL_DR:  return tms ? SEL_IR : CAP_DR;
      CAP_DR:  return tms ? EX1_DR : SH_DR;
      SH_DR:   return tms ? EX1_DR : SH_DR;
      EX1_DR:  return tms ? UPD_DR : PAU_DR;
      PAU_DR:  return tms ? EX2_DR : PAU_DR;
      EX2_DR:  return tms ? UPD_DR : SH_DR;
      UPD_DR:  return tms ? SEL_DR : RTI;
      SEL_IR:  return tms ? TLR    : CAP_IR;
      CAP_IR:  return tms ? EX1_IR : SH_IR;
      SH_IR:   return tms ? EX1_IR : SH_IR;
      EX1_IR:  return tms ? UPD_IR : PAU_IR;
      PAU_IR:  return tms ? EX2_IR : PAU_IR;
      EX2_IR:  return tms ? UPD_IR : SH_IR;
      UPD_IR:  return tms ? SEL_DR : RTI;
      default: return TLR;
    endcase
  endfunction

  // Capture/shift act on TCK rise in the state being left; update and TDO act on TCK fall.
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= TLR;
      ir                <= IR_IDCODE;
      ir_shift          <= '0;
      dr_shift          <= '0;
      jtag_TDO_data     <= 1'b0;
      jtag_TDO_driven   <= 1'b0;
      user_update_valid <= 1'b0;
      user_update_data  <= '0;
    end else begin
      user_update_valid <= 1'b0;
      if (!trstn_s) begin
        state <= TLR;
        ir    <= IR_IDCODE;
      end else begin
        if (tck_rise) begin
          state <= next_of(state, tms_s);
          case (state)
            CAP_IR: ir_shift <= 5'b00001;
            SH_IR:  ir_shift <= {tdi_s, ir_shift[4:1]};
            CAP_DR: begin
              if (ir == IR_IDCODE)    dr_shift <= IDCODE;
              else if (ir == IR_USER) dr_shift <= user_capture_data;
              else                    dr_shift <= '0;
            end
            SH_DR: begin
              if (wide_dr) dr_shift    <= {tdi_s, dr_shift[31:1]};
              else         dr_shift[0] <= tdi_s;
            end
            default: ;
          endcase
        end
        if (tck_fall) begin
          jtag_TDO_data   <= (state == SH_IR) ? ir_shift[0] : dr_shift[0];
          jtag_TDO_driven <= (state == SH_IR) || (state == SH_DR);
          if (state == UPD_IR) ir <= ir_shift;
          if (state == UPD_DR && ir == IR_USER) begin
            user_update_data  <= dr_shift;
            user_update_valid <= 1'b1;
          end
        end
        if (state == TLR) ir <= IR_IDCODE;
      end
    end
  end

  assign tap_state = state;

endmodule

// File: tb/tb_jtag_tap_sampled.sv
// Bench for jtag_tap_sampled: directed TAP walks and register scans plus random traffic,
// all compared against a queue-based behavioural TAP model.
module tb_jtag_tap_sampled;
  localparam int          SYNC = 2;
  localparam int          HALF = SYNC + 2;
  localparam logic [31:0] ID   = 32'h00000001;

  localparam int S_TLR = 15, S_RTI = 12, S_SDR = 7, S_CDR = 6, S_SHDR = 2, S_E1DR = 1;
  localparam int S_PDR = 3, S_E2DR = 0, S_UDR = 5, S_SIR = 4, S_CIR = 14, S_SHIR = 10;
  localparam int S_E1IR = 9, S_PIR = 11, S_E2IR = 8, S_UIR = 13;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        jtag_TCK = 1'b0, jtag_TMS = 1'b1, jtag_TDI = 1'b0, jtag_TRSTn = 1'b1;
  logic        jtag_TDO_data, jtag_TDO_driven;
  logic [31:0] user_capture_data = '0;
  logic        user_update_valid;
  logic [31:0] user_update_data;
  logic [3:0]  tap_state;

  jtag_tap_sampled #(.IDCODE(ID), .SYNC_STAGES(SYNC)) dut (
    .clock(clock), .reset(reset),
    .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TRSTn(jtag_TRSTn),
    .jtag_TDO_data(jtag_TDO_data), .jtag_TDO_driven(jtag_TDO_driven),
    .user_capture_data(user_capture_data), .user_update_valid(user_update_valid),
    .user_update_data(user_update_data), .tap_state(tap_state)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int dut_pulses = 0;

  always @(negedge clock) if (user_update_valid === 1'b1) dut_pulses++;

  // Reference model: IEEE 1149.1 transition table plus shift registers held as bit queues (front = LSB).
  int          nx0[16], nx1[16];
  int          m_state;
  logic [4:0]  m_ir;
  bit          m_irq[$], m_drq[$];
  logic        m_tdo, m_drv;
  logic [31:0] m_upd;
  int          m_pulses = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic set_arc(input int s, input int on0, input int on1);
    nx0[s] = on0;
    nx1[s] = on1;
  endtask

  function automatic logic [31:0] q2val(input bit q[$]);
    logic [31:0] v = '0;
    for (int i = 0; i < q.size() && i < 32; i++) v[i] = q[i];
    return v;
  endfunction

  task automatic model_reset();
    m_state = S_TLR; m_ir = 5'h01;
    m_irq.delete(); m_irq.push_back(1'b0);
    m_drq.delete(); m_drq.push_back(1'b0);
    m_tdo = 1'b0; m_drv = 1'b0; m_upd = '0;
  endtask

  task automatic model_rise(input logic tms, input logic tdi);
    logic [31:0] src;
    if (m_state == S_CIR) begin
      m_irq.delete(); m_irq.push_back(1'b1);
      repeat (4) m_irq.push_back(1'b0);
    end else if (m_state == S_CDR) begin
      m_drq.delete();
      if (m_ir == 5'h01 || m_ir == 5'h10) begin
        src = (m_ir == 5'h01) ? ID : user_capture_data;
        for (int i = 0; i < 32; i++) m_drq.push_back(src[i]);
      end else m_drq.push_back(1'b0);
    end else if (m_state == S_SHIR) begin
      void'(m_irq.pop_front()); m_irq.push_back(tdi);
    end else if (m_state == S_SHDR) begin
      void'(m_drq.pop_front()); m_drq.push_back(tdi);
    end
    m_state = tms ? nx1[m_state] : nx0[m_state];
    if (m_state == S_TLR) m_ir = 5'h01;
  endtask

  task automatic model_fall();
    logic [31:0] v;
    if (m_state == S_UIR) begin
      v = q2val(m_irq);
      m_ir = v[4:0];
    end
    if (m_state == S_UDR && m_ir == 5'h10) begin
      m_upd = q2val(m_drq);
      m_pulses++;
    end
    m_tdo = (m_state == S_SHIR) ? m_irq[0] : m_drq[0];
    m_drv = (m_state == S_SHIR) || (m_state == S_SHDR);
  endtask

  // One full TCK period: low phase with new TMS/TDI, rise, then fall; DUT compared after each settles.
  task automatic applyStimulus(input logic tms, input logic tdi, output logic tdo_seen);
    jtag_TMS = tms;
    jtag_TDI = tdi;
    repeat (HALF) @(negedge clock);
    jtag_TCK = 1'b1;
    model_rise(tms, tdi);
    repeat (HALF) @(negedge clock);
    checkOutput("state_after_rise", 64'(tap_state), 64'(m_state));
    jtag_TCK = 1'b0;
    model_fall();
    repeat (HALF) @(negedge clock);
    checkOutput("state_after_fall", 64'(tap_state), 64'(m_state));
    checkOutput("tdo_data", 64'(jtag_TDO_data), 64'(m_tdo));
    checkOutput("tdo_driven", 64'(jtag_TDO_driven), 64'(m_drv));
    checkOutput("update_data", 64'(user_update_data), 64'(m_upd));
    checkOutput("update_pulses", 64'(dut_pulses), 64'(m_pulses));
    tdo_seen = jtag_TDO_data;
  endtask

  task automatic applyReset();
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (HALF) @(negedge clock);
  endtask

  task automatic go_tlr_rti();
    logic t;
    repeat (5) applyStimulus(1'b1, 1'b0, t);
    applyStimulus(1'b0, 1'b0, t);
  endtask

  task automatic load_ir(input logic [4:0] code);
    logic t;
    applyStimulus(1'b1, 1'b0, t);
    applyStimulus(1'b1, 1'b0, t);
    applyStimulus(1'b0, 1'b0, t);
    applyStimulus(1'b0, 1'b0, t);
    for (int i = 0; i < 5; i++) applyStimulus(i == 4, code[i], t);
    applyStimulus(1'b1, 1'b0, t);
    applyStimulus(1'b0, 1'b0, t);
  endtask

  // From RTI: scan n bits through the selected DR and return to RTI; dout holds TDO LSB-first.
  task automatic shift_dr(input logic [63:0] din, input int n, output logic [63:0] dout);
    logic t;
    dout = '0;
    applyStimulus(1'b1, 1'b0, t);
    applyStimulus(1'b0, 1'b0, t);
    applyStimulus(1'b0, 1'b0, t);
    dout[0] = t;
    for (int i = 0; i < n; i++) begin
      applyStimulus(i == n - 1, din[i], t);
      if (i + 1 < n) dout[i + 1] = t;
    end
    applyStimulus(1'b1, 1'b0, t);
    applyStimulus(1'b0, 1'b0, t);
  endtask

  typedef struct {
    logic       tms;
    logic [3:0] exp_state;
    logic       exp_driven;
  } walk_vec_t;

  walk_vec_t   walk[23];
  logic [63:0] d;
  logic        t;
  int          p0;
  bit          hit;
  bit          at_rti;
  logic [4:0]  code;

  initial begin
    walk[0]  = '{1'b0, 4'd12, 1'b0}; walk[1]  = '{1'b1, 4'd7,  1'b0};
    walk[2]  = '{1'b1, 4'd4,  1'b0}; walk[3]  = '{1'b0, 4'd14, 1'b0};
    walk[4]  = '{1'b0, 4'd10, 1'b1}; walk[5]  = '{1'b1, 4'd9,  1'b0};
    walk[6]  = '{1'b0, 4'd11, 1'b0}; walk[7]  = '{1'b1, 4'd8,  1'b0};
    walk[8]  = '{1'b0, 4'd10, 1'b1}; walk[9]  = '{1'b1, 4'd9,  1'b0};
    walk[10] = '{1'b1, 4'd13, 1'b0}; walk[11] = '{1'b1, 4'd7,  1'b0};
    walk[12] = '{1'b0, 4'd6,  1'b0}; walk[13] = '{1'b1, 4'd1,  1'b0};
    walk[14] = '{1'b0, 4'd3,  1'b0}; walk[15] = '{1'b1, 4'd0,  1'b0};
    walk[16] = '{1'b0, 4'd2,  1'b1}; walk[17] = '{1'b1, 4'd1,  1'b0};
    walk[18] = '{1'b1, 4'd5,  1'b0}; walk[19] = '{1'b0, 4'd12, 1'b0};
    walk[20] = '{1'b1, 4'd7,  1'b0}; walk[21] = '{1'b1, 4'd4,  1'b0};
    walk[22] = '{1'b1, 4'd15, 1'b0};

    set_arc(S_TLR, S_RTI, S_TLR);    set_arc(S_RTI, S_RTI, S_SDR);
    set_arc(S_SDR, S_CDR, S_SIR);    set_arc(S_CDR, S_SHDR, S_E1DR);
    set_arc(S_SHDR, S_SHDR, S_E1DR); set_arc(S_E1DR, S_PDR, S_UDR);
    set_arc(S_PDR, S_PDR, S_E2DR);   set_arc(S_E2DR, S_SHDR, S_UDR);
    set_arc(S_UDR, S_RTI, S_SDR);    set_arc(S_SIR, S_CIR, S_TLR);
    set_arc(S_CIR, S_SHIR, S_E1IR);  set_arc(S_SHIR, S_SHIR, S_E1IR);
    set_arc(S_E1IR, S_PIR, S_UIR);   set_arc(S_PIR, S_PIR, S_E2IR);
    set_arc(S_E2IR, S_SHIR, S_UIR);  set_arc(S_UIR, S_RTI, S_SDR);

    applyReset();
    checkOutput("reset_state", 64'(tap_state), 64'd15);
    checkOutput("reset_driven", 64'(jtag_TDO_driven), 64'd0);
    checkOutput("reset_update_data", 64'(user_update_data), 64'd0);
    checkOutput("reset_update_valid", 64'(user_update_valid), 64'd0);

    for (int i = 0; i < 23; i++) begin
      applyStimulus(walk[i].tms, 1'b0, t);
      checkOutput("walk_state", 64'(tap_state), 64'(walk[i].exp_state));
      checkOutput("walk_driven", 64'(jtag_TDO_driven), 64'(walk[i].exp_driven));
    end

    applyReset();
    applyStimulus(1'b0, 1'b0, t);
    shift_dr(64'd0, 32, d);
    checkOutput("idcode_scan", d, 64'h00000001);

    load_ir(5'h1F);
    shift_dr(64'hD, 4, d);
    checkOutput("bypass_delay", d, 64'hA);

    user_capture_data = 32'hCAFEF00D;
    load_ir(5'h10);
    p0 = dut_pulses;
    shift_dr(64'h12345678, 32, d);
    checkOutput("user_capture_out", d, 64'hCAFEF00D);
    checkOutput("user_pulse_count", 64'(dut_pulses - p0), 64'd1);
    checkOutput("user_update_value", 64'(user_update_data), 64'h12345678);

    // TRSTn asserted in the middle of a USER scan.
    applyStimulus(1'b1, 1'b0, t);
    applyStimulus(1'b0, 1'b0, t);
    applyStimulus(1'b0, 1'b0, t);
    applyStimulus(1'b0, 1'b1, t);
    applyStimulus(1'b0, 1'b0, t);
    p0 = dut_pulses;
    jtag_TRSTn = 1'b0;
    m_state = S_TLR;
    m_ir = 5'h01;
    hit = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      if (k <= SYNC + 1 && tap_state == 4'd15) hit = 1'b1;
    end
    checkOutput("trst_latency", 64'(hit), 64'd1);
    jtag_TRSTn = 1'b1;
    repeat (HALF) @(negedge clock);
    checkOutput("trst_no_pulse", 64'(dut_pulses - p0), 64'd0);
    applyStimulus(1'b0, 1'b0, t);
    shift_dr(64'd0, 32, d);
    checkOutput("trst_ir_idcode", d, 64'h00000001);

    load_ir(5'h07);
    shift_dr(64'hD, 4, d);
    checkOutput("unknown_ir_bypass", d, 64'hA);
    applyStimulus(1'b1, 1'b0, t);
    applyStimulus(1'b1, 1'b0, t);
    applyStimulus(1'b0, 1'b0, t);
    applyStimulus(1'b0, 1'b0, t);
    repeat (5) applyStimulus(1'b1, 1'b0, t);
    checkOutput("five_tms_ones", 64'(tap_state), 64'd15);
    applyStimulus(1'b0, 1'b0, t);
    shift_dr(64'd0, 32, d);
    checkOutput("tlr_ir_idcode", d, 64'h00000001);

    // Synchronous reset in the middle of a USER scan must not produce an update.
    load_ir(5'h10);
    applyStimulus(1'b1, 1'b0, t);
    applyStimulus(1'b0, 1'b0, t);
    applyStimulus(1'b0, 1'b0, t);
    repeat (3) applyStimulus(1'b0, 1'b1, t);
    p0 = dut_pulses;
    applyReset();
    checkOutput("midreset_state", 64'(tap_state), 64'd15);
    checkOutput("midreset_driven", 64'(jtag_TDO_driven), 64'd0);
    checkOutput("midreset_tdo", 64'(jtag_TDO_data), 64'd0);
    checkOutput("midreset_data", 64'(user_update_data), 64'd0);
    checkOutput("midreset_valid", 64'(user_update_valid), 64'd0);
    checkOutput("midreset_no_pulse", 64'(dut_pulses - p0), 64'd0);

    at_rti = 1'b0;
    for (int op = 0; op < 40; op++) begin
      case ($urandom_range(0, 3))
        0: begin
          if (!at_rti) go_tlr_rti();
          case ($urandom_range(0, 3))
            0:       code = 5'h01;
            1:       code = 5'h1F;
            2:       code = 5'($urandom);
            default: code = 5'h10;
          endcase
          load_ir(code);
          at_rti = 1'b1;
        end
        1: begin
          if (!at_rti) go_tlr_rti();
          user_capture_data = $urandom;
          shift_dr({$urandom, $urandom}, $urandom_range(1, 40), d);
          at_rti = 1'b1;
        end
        2: begin
          for (int k = 0; k < 8; k++)
            applyStimulus($urandom_range(0, 2) == 0, 1'($urandom), t);
          at_rti = 1'b0;
        end
        default: begin
          jtag_TRSTn = 1'b0;
          m_state = S_TLR;
          m_ir = 5'h01;
          repeat (HALF) @(negedge clock);
          jtag_TRSTn = 1'b1;
          repeat (HALF) @(negedge clock);
          checkOutput("rand_trst_state", 64'(tap_state), 64'd15);
          at_rti = 1'b0;
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
